engine_slew_limiter: RTL and testbench

- Sits between the two engine command registers (engines 1/3 and 2/4) and the four PPM engine output generators, in the CLK_CPU domain.
- Latches the 10-bit throttle targets written by the CPU, clamps them, and slews each channel toward its target at a bounded rate per tick.
- Enforces a command watchdog: if the CPU stops writing, every channel is driven to 0 (failsafe).
- Outputs use the same packed format as the command registers, so the block drops in unchanged in front of the PPM output generators.

---
 rtl/engine_pkg.sv | 22 ++
 rtl/slew_channel.sv | 51 +++++
 rtl/engine_slew_limiter.sv | 141 ++++++++++++++
 tb/tb_engine_slew_limiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/engine_pkg.sv
// Shared field layout, status bit positions and packing helper for the engine
// command/output words.
package engine_pkg;

    localparam int ENG_W      = 10;
    localparam int ENG_LO_LSB = 0;
    localparam int ENG_HI_LSB = 16;
    localparam int NUM_CH     = 4;

    typedef logic [ENG_W-1:0] eng_val_t;

    localparam int ST_FAILSAFE   = 0;
    localparam int ST_AT_TGT_LSB = 1;

    // Failsafe set and every channel sitting at its (zero) target.
    localparam logic [31:0] STATUS_RST = 32'h0000_001F;

    function automatic logic [31:0] pack_pair(input eng_val_t hi, input eng_val_t lo);
        return {6'b0, hi, 6'b0, lo};
    endfunction

endpackage

// File: rtl/slew_channel.sv
// One throttle channel: on each tick moves CUR toward TGT by at most STEP_UP
// (rising) or STEP_DOWN (falling), landing exactly on TGT without overshoot.
module slew_channel
    import engine_pkg::*;
#(
    parameter int STEP_UP   = 5,
    parameter int STEP_DOWN = 20
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             TICK,
    input  logic [ENG_W-1:0] TGT,
    output logic [ENG_W-1:0] CUR,
    output logic             AT_TGT
);

    localparam logic signed [ENG_W:0] UP_S     = (ENG_W+1)'(STEP_UP);
    localparam logic signed [ENG_W:0] DN_NEG_S = (ENG_W+1)'(-STEP_DOWN);

    eng_val_t                r_cur;
    logic signed [ENG_W:0]   w_diff;
    eng_val_t                w_next;

    // Small differences are applied whole, so the channel lands exactly on target.
    function automatic eng_val_t slew_step(input eng_val_t cur, input logic signed [ENG_W:0] d);
        eng_val_t res;
        if (d > UP_S)
            res = cur + ENG_W'(STEP_UP);
        else if (d < DN_NEG_S)
            res = cur - ENG_W'(STEP_DOWN);
        else
            res = cur + d[ENG_W-1:0];
        return res;
    endfunction

    always_comb begin
        w_diff = $signed({1'b0, TGT}) - $signed({1'b0, r_cur});
        w_next = slew_step(r_cur, w_diff);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_cur <= '0;
        else if (TICK)
            r_cur <= w_next;
    end

    assign CUR    = r_cur;
    assign AT_TGT = (r_cur == TGT);

endmodule

// File: rtl/engine_slew_limiter.sv
// Latches CPU throttle targets, clamps them, slews four channels toward them
// per tick, and drops every target to zero when the CPU stops writing.
module engine_slew_limiter
    import engine_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int STEP_UP    = 5,
    parameter int STEP_DOWN  = 20,
    parameter int VMAX       = 1000,
    parameter int WDOG_TICKS = 100
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        WE_13,
    input  logic [31:0] CMD_13,
    input  logic        WE_24,
    input  logic [31:0] CMD_24,
    output logic [31:0] OUT_13,
    output logic [31:0] OUT_24,
    output logic [31:0] STATUS
);

    localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam int             WW        = $clog2(WDOG_TICKS + 1);
    localparam logic [WW-1:0]  WDOG_LIM  = WW'(WDOG_TICKS);
    localparam eng_val_t       VMAX_V    = ENG_W'(VMAX);

    logic [TW-1:0]     r_tick_cnt;
    logic [WW-1:0]     r_wdog_cnt;
    logic              r_failsafe;
    eng_val_t          r_tgt [NUM_CH];
    logic [31:0]       r_out_13;
    logic [31:0]       r_out_24;
    logic [31:0]       r_status;

    logic              w_tick;
    logic              w_any_we;
    logic [WW-1:0]     w_wdog_next;
    logic              w_wdog_hit;
    eng_val_t          w_cur [NUM_CH];
    logic [NUM_CH-1:0] w_at;
    logic [31:0]       w_status;
    logic              w_unused;

    function automatic eng_val_t clamp_tgt(input eng_val_t v);
        return (v > VMAX_V) ? VMAX_V : v;
    endfunction

    assign w_tick   = (r_tick_cnt == TICK_LAST);
    assign w_any_we = WE_13 | WE_24;
    assign w_unused = ^{CMD_13[31:26], CMD_13[15:10], CMD_24[31:26], CMD_24[15:10]};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // A write always beats expiry: the hit is only raised in write-free cycles.
    always_comb begin
        w_wdog_next = r_wdog_cnt;
        if (w_tick && (r_wdog_cnt < WDOG_LIM))
            w_wdog_next = r_wdog_cnt + 1'b1;
        w_wdog_hit = !w_any_we && (w_wdog_next == WDOG_LIM);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wdog_cnt <= '0;
            r_failsafe <= 1'b1;
        end else if (w_any_we) begin
            r_wdog_cnt <= '0;
            r_failsafe <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_next;
            if (w_wdog_hit)
                r_failsafe <= 1'b1;
        end
    end

    // Channel order in r_tgt: 0=eng1, 1=eng2, 2=eng3, 3=eng4.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_CH; i++)
                r_tgt[i] <= '0;
        end else if (w_wdog_hit) begin
            for (int i = 0; i < NUM_CH; i++)
                r_tgt[i] <= '0;
        end else begin
            if (WE_13) begin
                r_tgt[0] <= clamp_tgt(CMD_13[ENG_LO_LSB +: ENG_W]);
                r_tgt[2] <= clamp_tgt(CMD_13[ENG_HI_LSB +: ENG_W]);
            end
            if (WE_24) begin
                r_tgt[1] <= clamp_tgt(CMD_24[ENG_LO_LSB +: ENG_W]);
                r_tgt[3] <= clamp_tgt(CMD_24[ENG_HI_LSB +: ENG_W]);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        slew_channel #(
            .STEP_UP   (STEP_UP),
            .STEP_DOWN (STEP_DOWN)
        ) u_ch (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .TICK    (w_tick),
            .TGT     (r_tgt[g]),
            .CUR     (w_cur[g]),
            .AT_TGT  (w_at[g])
        );
    end

    always_comb begin
        w_status = '0;
        w_status[ST_FAILSAFE] = r_failsafe;
        w_status[ST_AT_TGT_LSB +: NUM_CH] = w_at;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_out_13 <= '0;
            r_out_24 <= '0;
            r_status <= STATUS_RST;
        end else begin
            r_out_13 <= pack_pair(w_cur[2], w_cur[0]);
            r_out_24 <= pack_pair(w_cur[3], w_cur[1]);
            r_status <= w_status;
        end
    end

    assign OUT_13 = r_out_13;
    assign OUT_24 = r_out_24;
    assign STATUS = r_status;

endmodule

// File: tb/tb_engine_slew_limiter.sv
// Directed bench for engine_slew_limiter with a short tick and watchdog.
module tb_engine_slew_limiter;

    localparam int TICK_DIV   = 4;
    localparam int STEP_UP    = 5;
    localparam int STEP_DOWN  = 20;
    localparam int VMAX       = 1000;
    localparam int WDOG_TICKS = 10;

    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b0;
    logic        WE_13   = 1'b0;
    logic [31:0] CMD_13  = '0;
    logic        WE_24   = 1'b0;
    logic [31:0] CMD_24  = '0;
    logic [31:0] OUT_13;
    logic [31:0] OUT_24;
    logic [31:0] STATUS;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tb_ph    = 0;

    engine_slew_limiter #(
        .TICK_DIV   (TICK_DIV),
        .STEP_UP    (STEP_UP),
        .STEP_DOWN  (STEP_DOWN),
        .VMAX       (VMAX),
        .WDOG_TICKS (WDOG_TICKS)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .WE_13   (WE_13),
        .CMD_13  (CMD_13),
        .WE_24   (WE_24),
        .CMD_24  (CMD_24),
        .OUT_13  (OUT_13),
        .OUT_24  (OUT_24),
        .STATUS  (STATUS)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Phase of the tick divider: the edge after tb_ph==TICK_DIV-1 is a tick.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            tb_ph <= 0;
        else
            tb_ph <= (tb_ph == TICK_DIV - 1) ? 0 : tb_ph + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // ch: 0=eng1, 1=eng2, 2=eng3, 3=eng4
    function automatic logic [9:0] get_ch(input int ch);
        logic [9:0] v;
        case (ch)
            0:       v = OUT_13[9:0];
            1:       v = OUT_24[9:0];
            2:       v = OUT_13[25:16];
            default: v = OUT_24[25:16];
        endcase
        return v;
    endfunction

    task automatic write13(input logic [31:0] cmd);
        WE_13  = 1'b1;
        CMD_13 = cmd;
        step();
        WE_13  = 1'b0;
    endtask

    task automatic write24(input logic [31:0] cmd);
        WE_24  = 1'b1;
        CMD_24 = cmd;
        step();
        WE_24  = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        step();
        step();
        RESET_N = 1'b1;
        step();
    endtask

    // Returns the first new value of a channel (old value on timeout) and the cycle seen.
    task automatic wait_change(input int ch, input logic [9:0] old, output logic [9:0] nv, output int c);
        bit done;
        done = 1'b0;
        nv   = old;
        c    = cyc;
        for (int k = 0; k < 12 && !done; k++) begin
            step();
            if (get_ch(ch) != old) begin
                nv   = get_ch(ch);
                c    = cyc;
                done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        step();
        checks++; if (OUT_13 !== 32'h0) begin failures++; $display("FAIL reset_out13: got %h expected %h", OUT_13, 32'h0); end
        checks++; if (OUT_24 !== 32'h0) begin failures++; $display("FAIL reset_out24: got %h expected %h", OUT_24, 32'h0); end
        checks++; if (STATUS !== 32'h1F) begin failures++; $display("FAIL reset_status: got %h expected %h", STATUS, 32'h1F); end
        RESET_N = 1'b1;
        repeat (3) step();
        checks++; if (STATUS !== 32'h1F) begin failures++; $display("FAIL post_reset_status: got %h expected %h", STATUS, 32'h1F); end
        checks++; if (OUT_13 !== 32'h0) begin failures++; $display("FAIL post_reset_out13: got %h expected %h", OUT_13, 32'h0); end
    endtask

    task automatic test_ramp_up();
        logic [9:0] v, prev;
        int c, pc;
        write13(32'h0064_0032);
        prev = '0;
        pc   = 0;
        for (int i = 1; i <= 10; i++) begin
            wait_change(0, prev, v, c);
            checks++; if (v !== 10'(5 * i)) begin failures++; $display("FAIL ramp_ch1: got %0d expected %0d", v, 5 * i); end
            if (i > 1) begin
                checks++; if (c - pc !== TICK_DIV) begin failures++; $display("FAIL ramp_ch1_gap: got %0d expected %0d", c - pc, TICK_DIV); end
            end
            if (i == 1) begin
                checks++; if (STATUS[0] !== 1'b0) begin failures++; $display("FAIL ramp_failsafe: got %b expected 0", STATUS[0]); end
            end
            prev = v;
            pc   = c;
            if (i == 5) write13(32'h0064_0032);
        end
        checks++; if (STATUS[1] !== 1'b1) begin failures++; $display("FAIL ramp_at_tgt1: got %b expected 1", STATUS[1]); end
        checks++; if (STATUS[3] !== 1'b0) begin failures++; $display("FAIL ramp_at_tgt3: got %b expected 0", STATUS[3]); end
        checks++; if (get_ch(2) !== 10'd50) begin failures++; $display("FAIL ramp_ch3_mid: got %0d expected 50", get_ch(2)); end
        write13(32'h0064_0032);
        prev = 10'd50;
        for (int j = 11; j <= 20; j++) begin
            wait_change(2, prev, v, c);
            checks++; if (v !== 10'(5 * j)) begin failures++; $display("FAIL ramp_ch3: got %0d expected %0d", v, 5 * j); end
            prev = v;
            if (j == 15) write13(32'h0064_0032);
        end
    endtask

    task automatic test_step_down();
        logic [9:0] v, prev;
        logic [9:0] exp_seq [3];
        int c, pc;
        exp_seq[0] = 10'd30;
        exp_seq[1] = 10'd10;
        exp_seq[2] = 10'd3;
        write13(32'h0064_0003);
        prev = 10'd50;
        pc   = 0;
        for (int i = 0; i < 3; i++) begin
            wait_change(0, prev, v, c);
            checks++; if (v !== exp_seq[i]) begin failures++; $display("FAIL down_ch1: got %0d expected %0d", v, exp_seq[i]); end
            if (i > 0) begin
                checks++; if (c - pc !== TICK_DIV) begin failures++; $display("FAIL down_ch1_gap: got %0d expected %0d", c - pc, TICK_DIV); end
            end
            prev = v;
            pc   = c;
        end
        repeat (16) step();
        checks++; if (get_ch(0) !== 10'd3) begin failures++; $display("FAIL down_hold: got %0d expected 3", get_ch(0)); end
        checks++; if (STATUS !== 32'h1E) begin failures++; $display("FAIL down_status: got %h expected %h", STATUS, 32'h1E); end
    endtask

    task automatic test_clamp();
        logic [9:0] v;
        int c;
        write24(32'h03FF_03FF);
        wait_change(1, 10'd0, v, c);
        checks++; if (OUT_24 !== 32'h0005_0005) begin failures++; $display("FAIL clamp_first: got %h expected %h", OUT_24, 32'h0005_0005); end
        for (int k = 0; k < 26; k++) begin
            repeat (32) step();
            write24(32'h03FF_03FF);
        end
        repeat (8) step();
        checks++; if (OUT_24 !== 32'h03E8_03E8) begin failures++; $display("FAIL clamp_settle: got %h expected %h", OUT_24, 32'h03E8_03E8); end
        checks++; if (STATUS !== 32'h1E) begin failures++; $display("FAIL clamp_status: got %h expected %h", STATUS, 32'h1E); end
        checks++; if (OUT_13 !== 32'h0064_0003) begin failures++; $display("FAIL clamp_out13: got %h expected %h", OUT_13, 32'h0064_0003); end
    endtask

    task automatic test_watchdog();
        logic [9:0] v, vch;
        int c, cw, fs_c, ch_c;
        write13(32'h0064_0032);
        repeat (20) step();
        write13(32'h0064_0032);
        repeat (28) step();
        checks++; if (get_ch(0) !== 10'd50) begin failures++; $display("FAIL wdog_pre: got %0d expected 50", get_ch(0)); end
        write13(32'h0064_0032);
        cw   = cyc;
        fs_c = 0;
        ch_c = 0;
        vch  = 10'd50;
        for (int k = 0; k < 60 && ch_c == 0; k++) begin
            step();
            if (fs_c == 0 && STATUS[0] === 1'b1) fs_c = cyc;
            if (get_ch(0) != 10'd50) begin
                ch_c = cyc;
                vch  = get_ch(0);
            end
        end
        checks++; if (fs_c - cw < 38 || fs_c - cw > 41) begin failures++; $display("FAIL wdog_expiry_time: got %0d cycles expected 38..41", fs_c - cw); end
        checks++; if (vch !== 10'd30) begin failures++; $display("FAIL wdog_decay1: got %0d expected 30", vch); end
        checks++; if (ch_c - fs_c !== TICK_DIV) begin failures++; $display("FAIL wdog_decay_gap: got %0d expected %0d", ch_c - fs_c, TICK_DIV); end
        wait_change(0, 10'd30, v, c);
        checks++; if (v !== 10'd10) begin failures++; $display("FAIL wdog_decay2: got %0d expected 10", v); end
        checks++; if (c - ch_c !== TICK_DIV) begin failures++; $display("FAIL wdog_decay2_gap: got %0d expected %0d", c - ch_c, TICK_DIV); end
        write13(32'h0000_0014);
        step();
        checks++; if (STATUS[0] !== 1'b0) begin failures++; $display("FAIL wdog_clear: got %b expected 0", STATUS[0]); end
        wait_change(0, 10'd10, v, c);
        checks++; if (v !== 10'd15) begin failures++; $display("FAIL wdog_restart1: got %0d expected 15", v); end
        wait_change(0, 10'd15, v, c);
        checks++; if (v !== 10'd20) begin failures++; $display("FAIL wdog_restart2: got %0d expected 20", v); end
    endtask

    task automatic test_tick_we();
        int c0;
        do_reset();
        for (int k = 0; k < TICK_DIV && tb_ph != TICK_DIV - 1; k++) step();
        WE_24  = 1'b1;
        CMD_24 = 32'h0000_0028;
        step();
        WE_24  = 1'b0;
        c0 = cyc;
        repeat (4) step();
        checks++; if (get_ch(1) !== 10'd0) begin failures++; $display("FAIL tickwe_hold: got %0d expected 0", get_ch(1)); end
        checks++; if (STATUS[0] !== 1'b0) begin failures++; $display("FAIL tickwe_failsafe: got %b expected 0", STATUS[0]); end
        step();
        checks++; if (get_ch(1) !== 10'd5) begin failures++; $display("FAIL tickwe_first: got %0d expected 5", get_ch(1)); end
        for (int k = 0; k < 60 && (cyc - c0) < 39; k++) step();
        WE_13  = 1'b1;
        CMD_13 = 32'h0000_0007;
        step();
        WE_13  = 1'b0;
        repeat (6) step();
        checks++; if (STATUS[0] !== 1'b0) begin failures++; $display("FAIL expiry_we_failsafe: got %b expected 0", STATUS[0]); end
        checks++; if (get_ch(1) !== 10'd40) begin failures++; $display("FAIL expiry_we_ch2: got %0d expected 40", get_ch(1)); end
        checks++; if (get_ch(0) !== 10'd5) begin failures++; $display("FAIL expiry_we_ch1: got %0d expected 5", get_ch(0)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write13(32'h0000_0032);
        for (int k = 0; k < 40 && get_ch(0) != 10'd25; k++) step();
        checks++; if (get_ch(0) !== 10'd25) begin failures++; $display("FAIL mid_reach25: got %0d expected 25", get_ch(0)); end
        RESET_N = 1'b0;
        #1;
        checks++; if (OUT_13 !== 32'h0) begin failures++; $display("FAIL mid_reset_out13: got %h expected %h", OUT_13, 32'h0); end
        checks++; if (STATUS !== 32'h1F) begin failures++; $display("FAIL mid_reset_status: got %h expected %h", STATUS, 32'h1F); end
        step();
        RESET_N = 1'b1;
        repeat (20) step();
        checks++; if (OUT_13 !== 32'h0) begin failures++; $display("FAIL mid_after_out13: got %h expected %h", OUT_13, 32'h0); end
        checks++; if (STATUS !== 32'h1F) begin failures++; $display("FAIL mid_after_status: got %h expected %h", STATUS, 32'h1F); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_step_down();
        test_clamp();
        test_watchdog();
        test_tick_we();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
